// File: rtl/burst_reader.sv
// burst_reader: turns upstream FIFO occupancy into length-prefixed read
// bursts. When the FIFO holds at least BLEN beats, a request (r_valid/r_len)
// is issued; once accepted, exactly r_len+1 beats are passed straight from
// the FIFO read port to the m_* stream, with m_last on the final beat.
//
// Optional feature (macro BURST_READER_TIMEOUT_EN): a partial residue that
// sits in the FIFO for 2**TBITS-1 idle cycles is flushed as a shorter burst.
// Without the macro only full BLEN-beat bursts are issued.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   s_level            beats deliverable from the upstream FIFO
//   s_valid/s_ready    upstream FIFO read handshake, s_data read data
//   r_valid/r_ready    burst request handshake, r_len = beats-1
//   m_valid/m_ready    burst data stream, m_last on final beat, m_data
module burst_reader #(
    parameter int WIDTH = 8,
    parameter int ABITS = 4,
    parameter int BLEN  = 4,
    parameter int TBITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [ABITS:0]   s_level,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [7:0]       r_len,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [WIDTH-1:0] m_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [ABITS:0] FULL_LVL = (ABITS+1)'(BLEN);
    localparam logic [7:0]     FULL_LEN = 8'(BLEN - 1);

    state_t     state_q, state_d;
    logic [7:0] r_len_q, r_len_d;
    logic [7:0] beat_q, beat_d;

`ifdef BURST_READER_TIMEOUT_EN
    localparam logic [TBITS-1:0] TMO_MAX = '1;
    logic [TBITS-1:0] tmo_q, tmo_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            r_len_q <= '0;
            beat_q  <= '0;
`ifdef BURST_READER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            r_len_q <= r_len_d;
            beat_q  <= beat_d;
`ifdef BURST_READER_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        r_len_d = r_len_q;
        beat_d  = beat_q;
        r_valid = 1'b0;
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
`ifdef BURST_READER_TIMEOUT_EN
        // Default clear covers both "level dropped to zero" and "left IDLE".
        tmo_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A full burst always wins, even on the timeout cycle.
                if (s_level >= FULL_LVL) begin
                    r_len_d = FULL_LEN;
                    state_d = ST_REQ;
                end
`ifdef BURST_READER_TIMEOUT_EN
                else if (s_level != '0) begin
                    if (tmo_q == TMO_MAX) begin
                        r_len_d = 8'(s_level - (ABITS+1)'(1));
                        state_d = ST_REQ;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
            end
            ST_REQ: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                // Pure pass-through: the FIFO read port is the stream.
                m_valid = s_valid;
                s_ready = m_ready;
                m_data  = s_data;
                m_last  = s_valid && (beat_q == r_len_q);
                if (s_valid && m_ready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == r_len_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign r_len = r_len_q;

endmodule

// File: tb/tb_burst_reader.sv
// Directed bench for burst_reader (default parameters). Drives the upstream
// FIFO port directly with s_data = base + beat index and checks the request
// and stream outputs against hand-computed values.
module tb_burst_reader;

    logic       clock;
    logic       reset;
    logic [4:0] s_level;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       r_valid;
    logic       r_ready;
    logic [7:0] r_len;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
    logic [7:0] m_data;

    int n_vec = 0;
    int n_err = 0;

    burst_reader #(.WIDTH(8), .ABITS(4), .BLEN(4), .TBITS(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .s_level (s_level),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .r_valid (r_valid),
        .r_ready (r_ready),
        .r_len   (r_len),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_data  (m_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // Waits for a request, optionally holds r_ready low for 'hold' cycles,
    // then streams nbeats beats. abort_at>0 stops after that many beats
    // with the DUT still in the data phase.
    task automatic run_burst(input logic [7:0] base, input int nbeats, input int exp_len,
                             input int hold, input bit tog, input bit keep_level,
                             input int wait_lim, input int abort_at, output int waited);
        int k;
        int cyc;
        waited  = 0;
        r_ready = (hold == 0);
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = base;
        sample();
        while (!r_valid && waited < wait_lim) begin
            expect_eq("idle_s_ready", {31'd0, s_ready}, 32'd0);
            step();
            waited++;
            sample();
        end
        expect_eq("req_seen", {31'd0, r_valid}, 32'd1);
        if (!r_valid) return;
        expect_eq("req_len", {24'd0, r_len}, exp_len);
        if (!keep_level) s_level = 5'd0;
        for (int h = 0; h < hold; h++) begin
            expect_eq("hold_r_valid", {31'd0, r_valid}, 32'd1);
            expect_eq("hold_r_len", {24'd0, r_len}, exp_len);
            expect_eq("hold_m_valid", {31'd0, m_valid}, 32'd0);
            expect_eq("hold_s_ready", {31'd0, s_ready}, 32'd0);
            step();
            sample();
        end
        r_ready = 1'b1;
        step();
        k   = 0;
        cyc = 0;
        while (k < nbeats && cyc < 64) begin
            if (abort_at > 0 && k == abort_at) return;
            m_ready = tog ? cyc[0] : 1'b1;
            s_valid = 1'b1;
            s_data  = base + 8'(k);
            sample();
            expect_eq("beat_valid", {31'd0, m_valid}, 32'd1);
            expect_eq("beat_data", {24'd0, m_data}, {24'd0, base + 8'(k)});
            expect_eq("beat_s_ready", {31'd0, s_ready}, {31'd0, m_ready});
            expect_eq("beat_last", {31'd0, m_last}, (k == nbeats - 1) ? 32'd1 : 32'd0);
            expect_eq("beat_no_req", {31'd0, r_valid}, 32'd0);
            if (m_ready) k++;
            step();
            cyc++;
        end
        expect_eq("beats_done", k, nbeats);
        // First cycle after the last beat: back in IDLE, nothing moves.
        s_valid = 1'b1;
        m_ready = 1'b1;
        sample();
        expect_eq("post_m_valid", {31'd0, m_valid}, 32'd0);
        expect_eq("post_s_ready", {31'd0, s_ready}, 32'd0);
        expect_eq("post_m_last", {31'd0, m_last}, 32'd0);
        expect_eq("post_r_valid", {31'd0, r_valid}, 32'd0);
        step();
    endtask

    initial begin : stim
        int w;
        bit saw;
        reset   = 1'b1;
        s_level = 5'd0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        r_ready = 1'b0;
        m_ready = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        sample();
        expect_eq("rst_r_valid", {31'd0, r_valid}, 32'd0);
        expect_eq("rst_r_len", {24'd0, r_len}, 32'd0);
        expect_eq("rst_m_valid", {31'd0, m_valid}, 32'd0);
        expect_eq("rst_s_ready", {31'd0, s_ready}, 32'd0);
        step();

        // Single full burst, everything ready.
        s_level = 5'd4;
        run_burst(8'hA0, 4, 3, 0, 1'b0, 1'b0, 8, 0, w);
        expect_eq("req_latency", w, 32'd1);

        // Request held off for 5 cycles.
        s_level = 5'd4;
        run_burst(8'h10, 4, 3, 5, 1'b0, 1'b0, 8, 0, w);

        // Downstream stalls every other cycle.
        s_level = 5'd4;
        run_burst(8'h20, 4, 3, 0, 1'b1, 1'b0, 8, 0, w);

        // Partial residue of two beats.
        s_level = 5'd2;
`ifdef BURST_READER_TIMEOUT_EN
        run_burst(8'h30, 2, 1, 0, 1'b0, 1'b0, 40, 0, w);
        expect_eq("tmo_latency", {31'd0, (w >= 15 && w <= 16)}, 32'd1);
`else
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (r_valid) saw = 1'b1;
            step();
        end
        expect_eq("no_partial_req", {31'd0, saw}, 32'd0);
        s_level = 5'd0;
        step();
`endif

        // Reset after two of four beats abandons the burst.
        s_level = 5'd4;
        run_burst(8'h40, 4, 3, 0, 1'b0, 1'b0, 8, 2, w);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        s_valid = 1'b1;
        m_ready = 1'b1;
        sample();
        expect_eq("abort_r_valid", {31'd0, r_valid}, 32'd0);
        expect_eq("abort_r_len", {24'd0, r_len}, 32'd0);
        expect_eq("abort_m_valid", {31'd0, m_valid}, 32'd0);
        expect_eq("abort_m_last", {31'd0, m_last}, 32'd0);
        expect_eq("abort_s_ready", {31'd0, s_ready}, 32'd0);
        step();
        s_level = 5'd4;
        run_burst(8'h50, 4, 3, 0, 1'b0, 1'b0, 8, 0, w);

        // Back-to-back: the request reappears right after the IDLE cycle.
        s_level = 5'd8;
        run_burst(8'h60, 4, 3, 0, 1'b0, 1'b1, 8, 0, w);
        run_burst(8'h64, 4, 3, 0, 1'b0, 1'b0, 8, 0, w);
        expect_eq("b2b_gap", w, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/burst_reader.md
BURST_READER -- requirements
Module: burst_reader

Interface
REQ-001 Parameter WIDTH, 8, data width in bits.
REQ-002 Parameter ABITS, 4, FIFO address bits; occupancy input is ABITS+1 bits wide.
REQ-003 Parameter BLEN, 4, beats per full burst, 1 <= BLEN <= 2**ABITS.
REQ-004 Parameter TBITS, 4, timeout counter width; timeout = 2**TBITS-1 idle cycles.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 s_level  input  ABITS+1  beats currently held by the upstream FIFO and guaranteed deliverable.
REQ-008 s_valid  input  1  upstream FIFO read-port data valid.
REQ-009 s_ready  output  1  read strobe to the upstream FIFO.
REQ-010 s_data  input  WIDTH  upstream FIFO read data.
REQ-011 r_valid  output  1  burst request valid.
REQ-012 r_ready  input  1  burst request accepted.
REQ-013 r_len  output  8  burst length minus one (AXI encoding), zero-extended.
REQ-014 m_valid / m_ready / m_last / m_data  output / input / output / output  1 / 1 / 1 / WIDTH  burst data stream.

Function
REQ-015 States: IDLE, REQ, DATA; one-hot or binary encoding is free.
REQ-016 IDLE: when s_level >= BLEN, register r_len = BLEN-1 and go to REQ; r_valid asserts the following cycle.
REQ-017 REQ: r_valid=1 and r_len stable until r_ready; on r_valid&&r_ready go to DATA next cycle.
REQ-018 DATA: m_valid=s_valid, s_ready=m_ready, m_data=s_data, all combinational; zero added latency per beat.
REQ-019 Beat counter clears on entry to DATA and increments on each s_valid&&s_ready.
REQ-020 m_last=1 when beat counter equals r_len and m_valid=1; on that transfer go to IDLE.
REQ-021 Outside DATA: m_valid=0, m_last=0, s_ready=0; no beat is consumed or emitted.
REQ-022 Stalls (s_valid=0 or m_ready=0) in DATA hold counter and state indefinitely.
REQ-023 r_valid and DATA never overlap; exactly r_len+1 beats follow each accepted request.
REQ-024 IDLE may issue a new request the cycle after the last beat; back-to-back bursts allowed.

Reset
REQ-025 reset forces IDLE, r_valid=0, r_len=0, beat counter=0, timeout counter=0.
REQ-026 reset mid-REQ or mid-DATA abandons the burst immediately; no partial m_last is generated.
REQ-027 All outputs stay 0 in the cycle following reset deassertion.

Configuration
REQ-028 Macro BURST_READER_TIMEOUT_EN enables partial-burst flushing.
REQ-029 With it: in IDLE with 0 < s_level < BLEN, timeout counter increments per cycle; clears when s_level=0, on leaving IDLE, or on reset.
REQ-030 With it: on counter reaching 2**TBITS-1, register r_len = s_level-1 and go to REQ.
REQ-031 With it: if s_level >= BLEN on the same cycle as timeout, a full burst (r_len=BLEN-1) is issued.
REQ-032 Without it: no timeout counter exists; only full BLEN-beat bursts are issued; residue waits indefinitely.

Verification
REQ-033 s_level=4, r_ready=1, m_ready=1, data 0xA0..0xA3 -> one request r_len=3, four beats 0xA0..0xA3, m_last on 0xA3.
REQ-034 r_ready held 0 for 5 cycles -> r_valid stays 1, r_len stable, m_valid=0, s_ready=0 throughout.
REQ-035 m_ready toggled every other cycle during a burst -> beats in order, none lost or duplicated, m_last only on beat 4.
REQ-036 TIMEOUT_EN, s_level=2 static -> request r_len=1 after 15 idle cycles, two beats, m_last on beat 2; without macro -> no request.
REQ-037 reset asserted after beat 2 of 4 -> next cycle IDLE, all outputs 0; new s_level=4 yields a fresh full burst.
REQ-038 s_level=8 constant, ready always 1 -> two consecutive bursts r_len=3, second request one cycle after first m_last.
